// File: rtl/dspl_page_sched_if.sv
// Write channel between a display client and the page scheduler.
// A digit write is accepted when wr_valid and wr_ready are both high at a rising edge.
interface dspl_page_sched_if;
  logic       wr_valid;
  logic       wr_ready;
  logic [1:0] wr_page;
  logic [2:0] wr_dig;
  logic [6:0] wr_data;

  modport master (output wr_valid, output wr_page, output wr_dig, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_page, input wr_dig, input wr_data, output wr_ready);
endinterface

// File: rtl/dspl_page_sched.sv
// Page scheduler for the 8-digit seven-segment driver: four pages of digit
// entries, a valid/ready write port, bulk clear, timed page rotation and per-digit blink.
module dspl_page_sched #(
  parameter int PAGE_TICKS  = 100000000,
  parameter int BLINK_TICKS = 25000000
) (
  input  logic              clock,
  input  logic              reset,
  dspl_page_sched_if.slave  wr,
  input  logic              clr_req,
  input  logic [3:0]        page_en,
  input  logic              hold,
  output logic [5:0]        d1,
  output logic [5:0]        d2,
  output logic [5:0]        d3,
  output logic [5:0]        d4,
  output logic [5:0]        d5,
  output logic [5:0]        d6,
  output logic [5:0]        d7,
  output logic [5:0]        d8,
  output logic [1:0]        cur_page,
  output logic              page_tick,
  output logic              busy
);

  localparam int TW = $clog2(PAGE_TICKS);
  localparam int BW = $clog2(BLINK_TICKS);

  typedef enum logic {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [4:0]      clr_idx_q, clr_idx_d;
  logic [6:0]      mem_q [32];
  logic [6:0]      mem_d [32];
  logic [TW-1:0]   tick_q, tick_d;
  logic [BW-1:0]   blink_q, blink_d;
  logic            phase_q, phase_d;
  logic [1:0]      cur_q, cur_d;
  logic            ptick_q, ptick_d;
  logic            busy_q, busy_d;
  logic [5:0]      dig_q [8];
  logic [5:0]      dig_d [8];
  logic            wr_fire_s;
  logic [1:0]      nxt_page_s;

  // Closest enabled page above cur (wrapping), or cur itself when no other page is enabled.
  function automatic logic [1:0] next_page(input logic [1:0] cur, input logic [3:0] en);
    logic [1:0] p;
    next_page = cur;
    for (int i = 3; i >= 1; i--) begin
      p = cur + 2'(i);
      if (en[p]) begin
        next_page = p;
      end else begin
        next_page = next_page;
      end
    end
  endfunction

  assign wr.wr_ready = (state_q == ST_IDLE) & ~clr_req;
  assign wr_fire_s   = wr.wr_valid & wr.wr_ready;
  assign nxt_page_s  = next_page(cur_q, page_en);

  // Storage update: client writes in IDLE, one entry zeroed per cycle in CLEAR.
  always_comb begin
    mem_d     = mem_q;
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    case (state_q)
      ST_IDLE: begin
        if (clr_req) begin
          state_d   = ST_CLEAR;
          clr_idx_d = 5'd0;
        end else if (wr_fire_s) begin
          mem_d[{wr.wr_page, wr.wr_dig}] = wr.wr_data;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        mem_d[clr_idx_q] = 7'd0;
        clr_idx_d        = clr_idx_q + 5'd1;
        if (clr_idx_q == 5'd31) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_CLEAR;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        clr_idx_d = 5'd0;
      end
    endcase
    busy_d = (state_d == ST_CLEAR);
  end

  // Page rotation; a disabled current page is left immediately even while held.
  always_comb begin
    tick_d  = tick_q;
    cur_d   = cur_q;
    ptick_d = 1'b0;
    if ((page_en != 4'd0) && !page_en[cur_q]) begin
      cur_d   = nxt_page_s;
      tick_d  = {TW{1'b0}};
      ptick_d = 1'b1;
    end else if (hold) begin
      tick_d = tick_q;
    end else if (tick_q == TW'(PAGE_TICKS - 1)) begin
      tick_d = {TW{1'b0}};
      if (nxt_page_s != cur_q) begin
        cur_d   = nxt_page_s;
        ptick_d = 1'b1;
      end else begin
        cur_d = cur_q;
      end
    end else begin
      tick_d = tick_q + TW'(1);
    end
  end

  // Free-running blink phase, independent of hold.
  always_comb begin
    if (blink_q == BW'(BLINK_TICKS - 1)) begin
      blink_d = {BW{1'b0}};
      phase_d = ~phase_q;
    end else begin
      blink_d = blink_q + BW'(1);
      phase_d = phase_q;
    end
  end

  // Digit words for the driver; blink gates only the enable bit.
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      if (page_en == 4'd0) begin
        dig_d[k] = 6'd0;
      end else begin
        dig_d[k] = {mem_q[{cur_q, 3'(k)}][5] & ~(mem_q[{cur_q, 3'(k)}][6] & phase_q),
                    mem_q[{cur_q, 3'(k)}][4:0]};
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      clr_idx_q <= 5'd0;
      for (int i = 0; i < 32; i++) mem_q[i] <= 7'd0;
      tick_q    <= {TW{1'b0}};
      blink_q   <= {BW{1'b0}};
      phase_q   <= 1'b0;
      cur_q     <= 2'd0;
      ptick_q   <= 1'b0;
      busy_q    <= 1'b0;
      for (int k = 0; k < 8; k++) dig_q[k] <= 6'd0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      for (int i = 0; i < 32; i++) mem_q[i] <= mem_d[i];
      tick_q    <= tick_d;
      blink_q   <= blink_d;
      phase_q   <= phase_d;
      cur_q     <= cur_d;
      ptick_q   <= ptick_d;
      busy_q    <= busy_d;
      for (int k = 0; k < 8; k++) dig_q[k] <= dig_d[k];
    end
  end

  assign d1        = dig_q[0];
  assign d2        = dig_q[1];
  assign d3        = dig_q[2];
  assign d4        = dig_q[3];
  assign d5        = dig_q[4];
  assign d6        = dig_q[5];
  assign d7        = dig_q[6];
  assign d8        = dig_q[7];
  assign cur_page  = cur_q;
  assign page_tick = ptick_q;
  assign busy      = busy_q;

endmodule

// File: doc/dspl_page_sched.md
# dspl_page_sched

Page scheduler and configuration front-end for the 8-digit Nexys A7 seven-segment driver. It stores four pages of eight 7-bit digit entries, accepts digit writes from a client through a valid/ready port and rotates the displayed page on a programmable period. It also applies a per-digit blink attribute. Outputs d1..d8 connect directly to the driver's digit inputs, using the same 6-bit format: bit5 enable, bits4:1 hex value, bit0 decimal point.

## Interface
- PAGE_TICKS, 100000000: clock cycles each page is displayed (1 s at 100 MHz); minimum 2.
- BLINK_TICKS, 25000000: clock cycles per blink half-period; minimum 2.
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset; one clock; all state is updated on the rising edge of clock.
- wr_valid  in  1  write request.
- wr_ready  out  1  write accepted when wr_valid & wr_ready at a rising edge.
- wr_page  in  2  target page 0..3.
- wr_dig  in  3  target digit 0..7; digit 0 maps to d1 (rightmost), digit 7 maps to d8.
- wr_data  in  7  bit6 blink, bit5 enable, bits4:1 hex, bit0 dp.
- clr_req  in  1  one-cycle pulse; clears all 32 entries.
- page_en  in  4  pages included in rotation.
- hold  in  1  freezes the rotation counter.
- d1..d8  out  6 each  registered digit words to the driver.
- cur_page  out  2  page currently displayed.
- page_tick  out  1  one-cycle pulse on each page change.
- busy  out  1  high while a clear is in progress.

## Operation
- Storage: 32 entries of 7 bits, page*8+digit.
- FSM states:
  - IDLE: wr_ready = ~clr_req. A clr_req in IDLE moves the FSM to CLEAR with clear index 0.
  - CLEAR: writes 0 to entry index, then increments index. Stays in CLEAR for exactly 32 cycles and returns to IDLE after index 31. During CLEAR, wr_ready=0 and busy=1. A clr_req received during CLEAR is ignored; the clear does not restart.
- Write and clear in the same IDLE cycle: the clear wins and the write is not accepted.
- Rotation:
  - tick counter counts 0..PAGE_TICKS-1 when hold=0.
  - At terminal count the counter returns to 0 and cur_page advances to the next enabled page, searching upward with wrap 3->0.
  - If cur_page is the only enabled page, cur_page is unchanged and page_tick does not pulse.
  - hold=1 freezes the counter and cur_page.
- Disabled current page: if page_en[cur_page]=0 and page_en!=0, cur_page moves to the next enabled page on the next edge, regardless of hold. The counter resets to 0 and page_tick pulses.
- page_en==0: cur_page is held, and all d outputs are forced to 6'b0 (blank).
- Blink: a free-running counter counts 0..BLINK_TICKS-1 and toggles phase at terminal count; phase=0 after reset. The counter is unaffected by hold.
- Output register, per digit k: dk = {e[5] & ~(e[6] & phase), e[4:1], e[0]}, where e = entry[cur_page*8+k-1].

## Timing
- Reset values:
  - all entries 0; FSM in IDLE.
  - d1..d8 = 0, cur_page = 0, page_tick = 0, busy = 0.
  - wr_ready follows IDLE & ~clr_req, so it is 1 when clr_req=0.
  - tick and blink counters 0; phase 0.
- Reset mid-CLEAR: the FSM goes to IDLE and all entries are 0 on the next cycle.
- Write latency: a write accepted at edge N updates storage at N. If it targets cur_page, the affected dk reflects it after edge N+1.
- Page change at edge N (cur_page updated): page_tick is high for the cycle after N, and the new page's data appears on dk after edge N+1.
- Blink phase change at edge N appears on dk after edge N+1.
- Clear of 32 entries: busy is high for 32 cycles starting the cycle after the clr_req edge. Blanked digits appear on the outputs with one extra cycle of lag.

## Test plan
Benches use PAGE_TICKS=8 and BLINK_TICKS=4.
- Reset, then write page0 dig3 data 7'h2B -> wr_ready=1 during the write; d4=6'h2B two edges later; all other d outputs 0.
- page_en=4'b0101, hold=0 -> cur_page sequence 0,2,0,2 with 8 cycles each; page_tick pulses every 8 cycles.
- With cur_page=2, set page_en=4'b0011 -> cur_page=0 on the next edge, page_tick=1 and the counter restarts.
- Page0 dig0 data 7'h61 -> d1 alternates 6'h21 / 6'h01 every 4 cycles; hold=1 does not stop the blink.
- Fill all pages, then pulse clr_req together with wr_valid -> write rejected; busy=1 for 32 cycles; all entries 0; wr_ready returns to 1 afterwards.
- Assert reset at clear index 10 -> busy=0 and all entries 0 on the next cycle; page_en=0 blanks all outputs.
